// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline hold/flush controller for the ysyx_23060072 core: load-use scoreboard,
// prioritised trap/branch redirect with a pending buffer, and stall/redirect counters.
module ysyx_23060072_pipe_ctrl #(
   parameter int NSTAGE = 5,
   parameter int EX_IDX = 2,
   parameter int XLEN   = 32,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stall_req_i,
   input  logic              if_ready_i,
   input  logic              id_valid_i,
   input  logic              id_rs1_en_i,
   input  logic              id_rs2_en_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rd_en_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_is_load_i,
   input  logic              br_redir_i,
   input  logic [XLEN-1:0]   br_pc_i,
   input  logic              trap_redir_i,
   input  logic [XLEN-1:0]   trap_pc_i,
   output logic [NSTAGE-1:0] hold_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              redir_o,
   output logic [XLEN-1:0]   redir_pc_o,
   output logic              load_use_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  redir_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic              rd_en;
      logic [REG_AW-1:0] rd;
      logic              is_load;
   } sb_t;

   sb_t               sb [EX_IDX:NSTAGE-1];
   logic              rst_q;
   logic              init;
   logic              pend_valid;
   logic              pend_trap;
   logic [XLEN-1:0]   pend_pc;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  redir_cnt;

   logic              hold_ex;
   logic              acc_trap;
   logic              acc_br;
   logic              redir_any;
   logic              lu_raw;
   logic              load_use;
   logic              pend_hold;
   logic              stall_run;
   logic [NSTAGE-1:0] chain;
   logic [NSTAGE-1:0] fmask;
   logic [NSTAGE-1:0] hold;
   logic [NSTAGE-1:0] flush;
   logic              new_take;
   logic              cand_valid;
   logic              cand_trap;
   logic [XLEN-1:0]   cand_pc;
   logic              redir;

   always_comb begin
      // Outputs keep their reset values for the cycle after rst drops too.
      init      = rst | rst_q;
      hold_ex   = |stall_req_i[NSTAGE-1:EX_IDX];
      acc_trap  = ~init & ~hold_ex & trap_redir_i;
      acc_br    = ~init & ~hold_ex & br_redir_i & ~trap_redir_i;
      redir_any = acc_trap | acc_br;

      lu_raw = id_valid_i & sb[EX_IDX].valid & sb[EX_IDX].is_load & sb[EX_IDX].rd_en
             & (sb[EX_IDX].rd != '0)
             & ((id_rs1_en_i & (id_rs1_i == sb[EX_IDX].rd)) |
                (id_rs2_en_i & (id_rs2_i == sb[EX_IDX].rd)));
      load_use  = lu_raw & ~redir_any & ~init;
      pend_hold = pend_valid & ~if_ready_i;

      // Downstream stalls accumulate from the top stage towards IF.
      stall_run = 1'b0;
      chain     = '0;
      fmask     = '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
         stall_run = stall_run | stall_req_i[NSTAGE-1-i];
         chain[NSTAGE-1-i] = stall_run
                           | (load_use & ((NSTAGE-1-i) < EX_IDX))
                           | (pend_hold & ((NSTAGE-1-i) == 0));
         fmask[i] = (acc_trap & (i <= EX_IDX)) | (acc_br & (i < EX_IDX));
      end

      hold  = '0;
      flush = '0;
      for (int unsigned i = 0; i < NSTAGE; i++)
         hold[i] = fmask[i] ? stall_req_i[i] : chain[i];
      flush[0] = fmask[0];
      for (int unsigned i = 1; i < NSTAGE; i++)
         flush[i] = fmask[i] | (hold[i-1] & ~hold[i]);
      if (init) begin
         hold  = '0;
         flush = '1;
      end

      // A fresh trap always wins; a fresh branch loses only to a pending trap.
      new_take   = acc_trap | (acc_br & ~(pend_valid & pend_trap));
      cand_valid = pend_valid | redir_any;
      cand_trap  = new_take ? acc_trap : pend_trap;
      cand_pc    = new_take ? (acc_trap ? trap_pc_i : br_pc_i) : pend_pc;
      redir      = ~init & cand_valid & if_ready_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q      <= 1'b1;
         pend_valid <= 1'b0;
         pend_trap  <= 1'b0;
         pend_pc    <= '0;
         stall_cnt  <= '0;
         redir_cnt  <= '0;
         for (int unsigned s = EX_IDX; s < NSTAGE; s++)
            sb[s] <= '0;
      end else begin
         rst_q      <= 1'b0;
         pend_valid <= cand_valid & ~if_ready_i & ~init;
         pend_trap  <= cand_trap;
         pend_pc    <= cand_pc;
         stall_cnt  <= stall_cnt + CNT_W'(hold[0]);
         redir_cnt  <= redir_cnt + CNT_W'(redir);
         if (!hold[EX_IDX]) begin
            if (flush[EX_IDX])
               sb[EX_IDX] <= '0;
            else
               sb[EX_IDX] <= '{valid: id_valid_i, rd_en: id_rd_en_i,
                               rd: id_rd_i, is_load: id_is_load_i};
         end
         for (int unsigned s = EX_IDX + 1; s < NSTAGE; s++) begin
            if (!hold[s])
               sb[s] <= flush[s] ? '0 : sb[s-1];
         end
      end
   end

   assign hold_o      = hold;
   assign flush_o     = flush;
   assign redir_o     = redir;
   assign redir_pc_o  = redir ? cand_pc : '0;
   assign load_use_o  = load_use;
   assign stall_cnt_o = stall_cnt;
   assign redir_cnt_o = redir_cnt;

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Self-checking bench for ysyx_23060072_pipe_ctrl: directed scenarios then random
// stimulus, every cycle compared against a behavioural model of the controller.
module tb_ysyx_23060072_pipe_ctrl;
   localparam int NSTAGE = 5;
   localparam int EX_IDX = 2;
   localparam int XLEN   = 32;
   localparam int REG_AW = 4;
   localparam int CNT_W  = 8;
   localparam int CMOD   = 1 << CNT_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NSTAGE-1:0] stall_req;
   logic              if_ready, id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_is_load;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic              br_redir, trap_redir;
   logic [XLEN-1:0]   br_pc, trap_pc;
   logic [NSTAGE-1:0] hold, flush;
   logic              redir, load_use;
   logic [XLEN-1:0]   redir_pc;
   logic [CNT_W-1:0]  stall_cnt, redir_cnt;

   ysyx_23060072_pipe_ctrl #(
      .NSTAGE(NSTAGE), .EX_IDX(EX_IDX), .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .if_ready_i(if_ready),
      .id_valid_i(id_valid), .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_en_i(id_rd_en), .id_rd_i(id_rd),
      .id_is_load_i(id_is_load), .br_redir_i(br_redir), .br_pc_i(br_pc),
      .trap_redir_i(trap_redir), .trap_pc_i(trap_pc), .hold_o(hold), .flush_o(flush),
      .redir_o(redir), .redir_pc_o(redir_pc), .load_use_o(load_use),
      .stall_cnt_o(stall_cnt), .redir_cnt_o(redir_cnt)
   );

   // Model of the instruction occupying each stage from EX upwards.
   typedef struct { bit v; bit rd_en; bit ld; int rd; } ent_t;
   ent_t            sbm [NSTAGE];
   bit              m_pv, m_pt, m_init;
   logic [XLEN-1:0] m_ppc;
   int              m_stall, m_redir;

   logic [NSTAGE-1:0] e_hold, e_flush;
   logic              e_redir, e_lu;
   logic [XLEN-1:0]   e_pc;
   int nchk = 0;
   int nerr = 0;
   int base;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic eval();
      bit busy, tt, tb_, haz, have, istrap, h;
      int kill;
      logic [XLEN-1:0] tgt;
      ent_t ex;
      #2;
      e_hold = '0; e_flush = '0; e_redir = 1'b0; e_pc = '0; e_lu = 1'b0;
      have = 0; istrap = 0; tgt = '0; kill = 0;
      if (rst || m_init) begin
         e_flush = '1;
      end else begin
         busy = 0;
         for (int t = EX_IDX; t < NSTAGE; t++) if (stall_req[t]) busy = 1;
         tt   = trap_redir && !busy;
         tb_  = br_redir && !busy && !trap_redir;
         kill = tt ? EX_IDX + 1 : (tb_ ? EX_IDX : 0);
         ex   = sbm[EX_IDX];
         haz  = id_valid && ex.v && ex.ld && ex.rd_en && ex.rd != 0 &&
                ((id_rs1_en && int'(id_rs1) == ex.rd) || (id_rs2_en && int'(id_rs2) == ex.rd)) &&
                kill == 0;
         for (int s = 0; s < NSTAGE; s++) begin
            h = 0;
            for (int t = s; t < NSTAGE; t++) if (stall_req[t]) h = 1;
            if (haz && s < EX_IDX) h = 1;
            if (s == 0 && m_pv && !if_ready) h = 1;
            if (s < kill) h = stall_req[s];
            e_hold[s] = h;
         end
         for (int s = 0; s < NSTAGE; s++)
            e_flush[s] = (s < kill) || (s > 0 && e_hold[s-1] && !e_hold[s]);
         if (tt) begin have = 1; istrap = 1; tgt = trap_pc; end
         else if (tb_ && !(m_pv && m_pt)) begin have = 1; istrap = 0; tgt = br_pc; end
         else if (m_pv) begin have = 1; istrap = m_pt; tgt = m_ppc; end
         e_lu    = haz;
         e_redir = have && if_ready;
         e_pc    = e_redir ? tgt : '0;
      end

      chk("hold", 64'(hold), 64'(e_hold));
      chk("flush", 64'(flush), 64'(e_flush));
      chk("redir", 64'(redir), 64'(e_redir));
      chk("redir_pc", 64'(redir_pc), 64'(e_pc));
      chk("load_use", 64'(load_use), 64'(e_lu));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("redir_cnt", 64'(redir_cnt), 64'(m_redir));

      if (rst) begin
         foreach (sbm[i]) sbm[i] = '{0, 0, 0, 0};
         m_pv = 0; m_pt = 0; m_ppc = '0; m_stall = 0; m_redir = 0; m_init = 1;
      end else begin
         m_init  = 0;
         m_stall = (m_stall + int'(e_hold[0])) % CMOD;
         m_redir = (m_redir + int'(e_redir)) % CMOD;
         for (int s = NSTAGE - 1; s >= EX_IDX; s--) begin
            if (!e_hold[s]) begin
               if (e_flush[s]) sbm[s] = '{0, 0, 0, 0};
               else if (s == EX_IDX) sbm[s] = '{id_valid, id_rd_en, id_is_load, int'(id_rd)};
               else sbm[s] = sbm[s-1];
            end
         end
         if (have && !if_ready) begin m_pv = 1; m_pt = istrap; m_ppc = tgt; end
         else m_pv = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      stall_req = '0; if_ready = 1'b1; id_valid = 1'b0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_rd_en = 1'b0; id_rd = '0; id_is_load = 1'b0;
      br_redir = 1'b0; trap_redir = 1'b0; br_pc = '0; trap_pc = '0;
   endtask

   initial begin
      m_init = 0; m_pv = 0; m_pt = 0; m_ppc = '0; m_stall = 0; m_redir = 0;
      foreach (sbm[i]) sbm[i] = '{0, 0, 0, 0};
      quiet();
      rst = 1'b1;
      tick();
      eval(); chk("rst_flush", 64'(flush), 64'h1f); chk("rst_hold", 64'(hold), 64'h0); tick();
      eval(); tick();
      rst = 1'b0;
      eval(); chk("post_rst_flush", 64'(flush), 64'h1f); tick();

      // Load x5 followed by add x6,x5,x1.
      id_valid = 1'b1; id_rd_en = 1'b1; id_rd = 4'd5; id_is_load = 1'b1;
      eval(); tick();
      id_is_load = 1'b0; id_rd = 4'd6; id_rs1_en = 1'b1; id_rs1 = 4'd5; id_rs2_en = 1'b1; id_rs2 = 4'd1;
      eval();
      chk("lu_hold", 64'(hold), 64'h03); chk("lu_flush", 64'(flush), 64'h04);
      chk("lu_flag", 64'(load_use), 64'h1);
      tick();
      eval(); chk("lu_clear", 64'(load_use), 64'h0); chk("lu_nohold", 64'(hold), 64'h0); tick();

      // Load into x0 never stalls a reader of x0.
      quiet(); id_valid = 1'b1; id_rd_en = 1'b1; id_rd = 4'd0; id_is_load = 1'b1;
      eval(); tick();
      id_is_load = 1'b0; id_rd = 4'd7; id_rs1_en = 1'b1; id_rs1 = 4'd0;
      eval(); chk("x0_lu", 64'(load_use), 64'h0); chk("x0_hold", 64'(hold), 64'h0); tick();

      // Three-cycle LSU stall in stage 3.
      quiet(); stall_req = 5'b01000;
      base = m_stall;
      for (int i = 0; i < 3; i++) begin
         eval(); chk("lsu_hold", 64'(hold), 64'h0f); chk("lsu_flush4", 64'(flush[4]), 64'h1); tick();
      end
      stall_req = '0;
      eval(); chk("lsu_cnt", 64'(stall_cnt), 64'((base + 3) % CMOD)); tick();

      // Branch with IF ready.
      base = m_redir;
      br_redir = 1'b1; br_pc = 32'h8000_0040;
      eval();
      chk("br_redir", 64'(redir), 64'h1); chk("br_pc", 64'(redir_pc), 64'h8000_0040);
      chk("br_flush", 64'(flush), 64'h03);
      tick();
      br_redir = 1'b0;
      eval(); chk("br_cnt", 64'(redir_cnt), 64'((base + 1) % CMOD)); tick();

      // Trap overrides a pending branch; one delivery.
      base = m_redir;
      if_ready = 1'b0; br_redir = 1'b1; br_pc = 32'h100;
      eval(); chk("pend_br_noredir", 64'(redir), 64'h0); tick();
      br_redir = 1'b0; trap_redir = 1'b1; trap_pc = 32'h200;
      eval(); chk("pend_tr_flush", 64'(flush), 64'h07); tick();
      trap_redir = 1'b0;
      eval(); chk("pend_wait", 64'(redir), 64'h0); chk("pend_if_hold", 64'(hold[0]), 64'h1); tick();
      if_ready = 1'b1;
      eval(); chk("pend_deliver", 64'(redir), 64'h1); chk("pend_pc", 64'(redir_pc), 64'h200); tick();
      eval(); chk("pend_single", 64'(redir), 64'h0);
      chk("pend_cnt", 64'(redir_cnt), 64'((base + 1) % CMOD)); tick();

      // Reset discards a pending redirect.
      if_ready = 1'b0; br_redir = 1'b1; br_pc = 32'h300;
      eval(); tick();
      br_redir = 1'b0; if_ready = 1'b1; rst = 1'b1;
      eval(); chk("rstp_redir", 64'(redir), 64'h0); chk("rstp_flush", 64'(flush), 64'h1f); tick();
      rst = 1'b0;
      eval(); chk("rstp_redir2", 64'(redir), 64'h0); tick();
      eval(); chk("rstp_redir3", 64'(redir), 64'h0);
      chk("rstp_scnt", 64'(stall_cnt), 64'h0); chk("rstp_rcnt", 64'(redir_cnt), 64'h0); tick();

      // Random traffic; small register range makes hazards common.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         for (int s = 0; s < NSTAGE; s++) stall_req[s] = ($urandom_range(0, 9) == 0);
         if_ready   = ($urandom_range(0, 9) < 7);
         id_valid   = ($urandom_range(0, 9) < 8);
         id_rs1_en  = $urandom_range(0, 1);
         id_rs2_en  = $urandom_range(0, 1);
         id_rs1     = REG_AW'($urandom_range(0, 3));
         id_rs2     = REG_AW'($urandom_range(0, 3));
         id_rd_en   = ($urandom_range(0, 9) < 8);
         id_rd      = REG_AW'($urandom_range(0, 3));
         id_is_load = ($urandom_range(0, 9) < 4);
         br_redir   = ($urandom_range(0, 9) == 0);
         trap_redir = ($urandom_range(0, 19) == 0);
         br_pc      = $urandom;
         trap_pc    = $urandom;
         eval();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
